// File: rtl/pipe_stage_fifo_pkg.sv
// Shared definitions for pipeline-stage buffers: occupancy width helper,
// the NOP payload constant and the stage payload bundles cast to DATA_W.
package pipe_pkg;

  localparam int PIPE_MAX_DEPTH = 8;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // EX/MEM field bundle, flattened to DATA_W where the stage buffer is instantiated
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
  } ex_mem_t;

  localparam ex_mem_t PIPE_NOP = '0;

endpackage

// File: rtl/pipe_stage_fifo_wrap_ptr.sv
// Index pointer that wraps at DEPTH-1 (works for non-power-of-two depths)
// with a synchronous clear used by the stage flush.
module wrap_ptr #(
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/pipe_stage_fifo.sv
// In-order pipeline-stage buffer with valid/ready on both sides, a global
// stall (lock) and a kill (flush). An empty stage shows an all-zero payload.
module pipe_stage_fifo
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  localparam int CNT_W = cnt_w(DEPTH),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              lock,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              push;
  logic              pop;

  // in_ready depends only on local state, so out_ready never reaches it
  assign in_ready  = !lock && !flush && (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !lock && !flush;

  wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_b (rst_b),
    .clr   (flush),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_b (rst_b),
    .clr   (flush),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr] = in_data;
    end
  end

  // Storage is deliberately unreset; the output mask below hides stale entries
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_data = out_valid ? mem_q[rd_ptr] : '0;
  assign count    = count_q;

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Self-checking bench: a DEPTH=2 and a DEPTH=3 instance checked every cycle
// against a queue model, plus literal expectations from the directed scenarios.
module tb_pipe_stage_fifo;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          lock_s      [2];
  logic          flush_s     [2];
  logic          in_valid_s  [2];
  logic          out_ready_s [2];
  logic [DW-1:0] in_data_s   [2];
  logic [DW-1:0] out_data_s  [2];
  logic          in_ready_s  [2];
  logic          out_valid_s [2];
  logic [1:0]    count_s     [2];

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] mq [2][$];

  always #5 clk = ~clk;

  pipe_stage_fifo #(.DATA_W(DW), .DEPTH(2)) dut2 (
    .clk       (clk),
    .rst_b     (rst),
    .lock      (lock_s[0]),
    .flush     (flush_s[0]),
    .in_valid  (in_valid_s[0]),
    .in_data   (in_data_s[0]),
    .in_ready  (in_ready_s[0]),
    .out_valid (out_valid_s[0]),
    .out_data  (out_data_s[0]),
    .out_ready (out_ready_s[0]),
    .count     (count_s[0])
  );

  pipe_stage_fifo #(.DATA_W(DW), .DEPTH(3)) dut3 (
    .clk       (clk),
    .rst_b     (rst),
    .lock      (lock_s[1]),
    .flush     (flush_s[1]),
    .in_valid  (in_valid_s[1]),
    .in_data   (in_data_s[1]),
    .in_ready  (in_ready_s[1]),
    .out_valid (out_valid_s[1]),
    .out_data  (out_data_s[1]),
    .out_ready (out_ready_s[1]),
    .count     (count_s[1])
  );

  function automatic int depthOf(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int i, input logic v, input logic [DW-1:0] d,
                               input logic ordy, input logic lk, input logic fl);
    @(posedge clk);
    #1;
    in_valid_s[i]  = v;
    in_data_s[i]   = d;
    out_ready_s[i] = ordy;
    lock_s[i]      = lk;
    flush_s[i]     = fl;
  endtask

  // Reference model: a plain queue per instance updated from the handshake rules
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq[0].delete();
        mq[1].delete();
      end else begin
        for (int i = 0; i < 2; i++) begin
          bit can_acc;
          bit do_push;
          bit do_pop;
          can_acc = !lock_s[i] && !flush_s[i] && (mq[i].size() < depthOf(i));
          do_push = in_valid_s[i] && can_acc;
          do_pop  = (mq[i].size() != 0) && out_ready_s[i] && !lock_s[i] && !flush_s[i];
          if (flush_s[i]) begin
            mq[i].delete();
          end else begin
            if (do_pop) void'(mq[i].pop_front());
            if (do_push) mq[i].push_back(in_data_s[i]);
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, well clear of the clock edge
  initial begin
    forever begin
      @(posedge clk);
      #8;
      for (int i = 0; i < 2; i++) begin
        int            sz;
        logic          exp_ir;
        logic [DW-1:0] exp_data;
        sz       = mq[i].size();
        exp_ir   = !lock_s[i] && !flush_s[i] && (sz < depthOf(i));
        exp_data = (sz != 0) ? mq[i][0] : '0;
        checkOutput($sformatf("count[%0d]", i), DW'(count_s[i]), DW'(sz));
        checkOutput($sformatf("in_ready[%0d]", i), DW'(in_ready_s[i]), DW'(exp_ir));
        checkOutput($sformatf("out_valid[%0d]", i), DW'(out_valid_s[i]), DW'(sz != 0));
        checkOutput($sformatf("out_data[%0d]", i), out_data_s[i], exp_data);
      end
    end
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      lock_s[i]      = 1'b0;
      flush_s[i]     = 1'b0;
      in_valid_s[i]  = 1'b0;
      out_ready_s[i] = 1'b0;
      in_data_s[i]   = '0;
    end
    #3;
    checkOutput("por_in_ready", DW'(in_ready_s[0]), 32'd1);
    checkOutput("por_out_valid", DW'(out_valid_s[1]), 32'd0);
    checkOutput("por_count", DW'(count_s[1]), 32'd0);
    #9;
    rst = 1'b0;

    // Reset mid-traffic on the DEPTH=2 instance
    applyStimulus(0, 1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #3;
    checkOutput("pre_rst_count", DW'(count_s[0]), 32'd2);
    checkOutput("pre_rst_head", out_data_s[0], 32'hA);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_out_valid", DW'(out_valid_s[0]), 32'd0);
    checkOutput("rst_out_data", out_data_s[0], 32'h0);
    checkOutput("rst_count", DW'(count_s[0]), 32'd0);
    checkOutput("rst_in_ready", DW'(in_ready_s[0]), 32'd1);
    #3;
    rst = 1'b0;

    // Streaming: each word is at the head exactly one cycle after its push
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(0, 1'b1, DW'(k), 1'b1, 1'b0, 1'b0);
      #5;
      checkOutput("stream_ready", DW'(in_ready_s[0]), 32'd1);
      if (k > 1) checkOutput("stream_head", out_data_s[0], DW'(k - 1));
    end
    applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    #5;
    checkOutput("stream_last", out_data_s[0], 32'h10);
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Full / backpressure on the DEPTH=3 instance
    applyStimulus(1, 1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 32'h6, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 32'h7, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 32'h8, 1'b0, 1'b0, 1'b0);
    #5;
    checkOutput("full_count", DW'(count_s[1]), 32'd3);
    checkOutput("full_in_ready", DW'(in_ready_s[1]), 32'd0);
    applyStimulus(1, 1'b1, 32'h8, 1'b1, 1'b0, 1'b0);
    #5;
    checkOutput("full_pop_no_accept", DW'(in_ready_s[1]), 32'd0);
    checkOutput("drain_5", out_data_s[1], 32'h5);
    applyStimulus(1, 1'b1, 32'h8, 1'b1, 1'b0, 1'b0);
    #5;
    checkOutput("accept_8", DW'(in_ready_s[1]), 32'd1);
    checkOutput("drain_6", out_data_s[1], 32'h6);
    applyStimulus(1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    #5;
    checkOutput("drain_7", out_data_s[1], 32'h7);
    applyStimulus(1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    #5;
    checkOutput("drain_8", out_data_s[1], 32'h8);
    applyStimulus(1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #5;
    checkOutput("empty_nop", out_data_s[1], 32'h0);

    // Wrap-around with occupancy held at one
    applyStimulus(1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1, 1'b1, DW'(32'h101 + k), 1'b1, 1'b0, 1'b0);
      #5;
      checkOutput("wrap_head", out_data_s[1], DW'(32'h100 + k));
      checkOutput("wrap_count", DW'(count_s[1]), 32'd1);
    end
    applyStimulus(1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Lock holds everything, then the head pops on release
    applyStimulus(0, 1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 32'h33, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1'b1, 32'h44, 1'b1, 1'b1, 1'b0);
      #5;
      checkOutput("lock_count", DW'(count_s[0]), 32'd2);
      checkOutput("lock_head", out_data_s[0], 32'h22);
      checkOutput("lock_in_ready", DW'(in_ready_s[0]), 32'd0);
    end
    applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    #5;
    checkOutput("unlock_head", out_data_s[0], 32'h22);
    applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    #5;
    checkOutput("after_pop_head", out_data_s[0], 32'h33);
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Flush overrides lock and drops the offered word
    applyStimulus(0, 1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 32'h66, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 32'h99, 1'b0, 1'b1, 1'b1);
    #5;
    checkOutput("flush_in_ready", DW'(in_ready_s[0]), 32'd0);
    applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    #5;
    checkOutput("flush_count", DW'(count_s[0]), 32'd0);
    checkOutput("flush_out_data", out_data_s[0], 32'h0);
    checkOutput("flush_out_valid", DW'(out_valid_s[0]), 32'd0);
    applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #9;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
